// File: rtl/jk_pkg.sv
// Shared JK excitation codes, controller states and the per-bit excitation
// function used by the JK flip-flop bank driver.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK
   } state_t;

   // Inverse JK table: the don't-care half of each code is filled with dc_fill.
   function automatic logic [1:0] jk_excite(input logic q, input logic d, input logic dc_fill);
      logic [1:0] code;
      case ({q, d})
         2'b00:   code = {1'b0, dc_fill};
         2'b01:   code = {1'b1, dc_fill};
         2'b10:   code = {dc_fill, 1'b1};
         default: code = {dc_fill, 1'b0};
      endcase
      return code;
   endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Combinational excitation for one JK flip-flop: present state and desired
// next state in, {J,K} out.
module jk_excite_bit
   import jk_pkg::*;
#(
   parameter bit DC_FILL = 1'b0
) (
   input  logic       q,
   input  logic       d,
   output logic [1:0] jk
);

   assign jk = jk_excite(q, d, DC_FILL);

endmodule

// File: rtl/jk_excite_drv.sv
// Drives a bank of W JK flip-flops to a requested state: one DRIVE cycle of
// excitation, one CHECK cycle against the feedback, bounded retries, sticky err.
module jk_excite_drv
   import jk_pkg::*;
#(
   parameter int W         = 4,
   parameter bit DC_FILL   = 1'b0,
   parameter int MAX_RETRY = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tgt_valid,
   output logic           tgt_ready,
   input  logic [W-1:0]   tgt_data,
   input  logic [W-1:0]   q_fb,
   output logic [2*W-1:0] jk_out,
   output logic           busy,
   output logic           done,
   output logic           err
);

   localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CW-1:0] RMAX = CW'(MAX_RETRY);

   state_t         state, state_nx;
   logic [W-1:0]   tgt_q, tgt_nx, d_sel;
   logic [CW-1:0]  retry, retry_nx;
   logic [2*W-1:0] jk_calc, jk_nx;
   logic           err_nx;
   logic           match;

   // First attempt excites toward the incoming word; retries toward the latched one.
   assign d_sel = (state == IDLE) ? tgt_data : tgt_q;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      jk_excite_bit #(.DC_FILL(DC_FILL)) u_bit (
         .q  (q_fb[gi]),
         .d  (d_sel[gi]),
         .jk (jk_calc[2*gi+1:2*gi])
      );
   end

   assign match = (q_fb == tgt_q);

   always_comb begin
      state_nx = state;
      tgt_nx   = tgt_q;
      retry_nx = retry;
      jk_nx    = {W{JK_HOLD}};
      err_nx   = err;
      case (state)
         IDLE: begin
            if (tgt_valid && !err) begin
               state_nx = DRIVE;
               tgt_nx   = tgt_data;
               retry_nx = '0;
               jk_nx    = jk_calc;
            end
         end
         DRIVE: state_nx = CHECK;
         CHECK: begin
            if (match) begin
               state_nx = IDLE;
            end else if (retry < RMAX) begin
               state_nx = DRIVE;
               retry_nx = retry + CW'(1);
               jk_nx    = jk_calc;
            end else begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         tgt_q  <= '0;
         retry  <= '0;
         jk_out <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         tgt_q  <= tgt_nx;
         retry  <= retry_nx;
         jk_out <= jk_nx;
         err    <= err_nx;
      end
   end

   // Gated by rst so neither handshake nor completion shows during a reset cycle.
   assign tgt_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);
   assign done      = (state == CHECK) && match && !rst;

endmodule
